ssg_emb_sd_adc_comb: RTL and testbench

Differentiator (comb) and output stage of the Sinc3 sigma-delta ADC channel. It consumes the third-stage integrator value and the decimation and latch strobes from the upstream integrator/strobe generator. It produces a signed 16-bit high-resolution sample with a valid pulse, and a fast low-resolution magnitude with a sticky overcurrent trip. Everything runs in the clk_adc domain.

---
 rtl/ssg_emb_sd_adc_comb.sv | 206 ++++++++++++++++++++
 tb/tb_ssg_emb_sd_adc_comb.sv | 270 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/ssg_emb_sd_adc_comb.sv
// Sinc3 comb and output stage of the sigma-delta ADC channel: a high-res signed sample path
// and a fast low-res magnitude path with a sticky overcurrent trip.
module ssg_emb_sd_adc_comb #(
    parameter int OC_PERSIST_W = 4
) (
    input  logic                    clk_adc,
    input  logic                    reset_adc_n,
    input  logic [21:0]             cn_in,
    input  logic                    cnr64,
    input  logic                    cnr16,
    input  logic                    latch_en,
    input  logic                    dec_rate,
    input  logic [11:0]             oc_threshold,
    input  logic [OC_PERSIST_W-1:0] oc_persist,
    input  logic                    oc_clear,
    output logic [15:0]             result,
    output logic                    result_valid,
    output logic                    result_sat,
    output logic [11:0]             lr_mag,
    output logic                    oc_trip
);

    localparam logic [2:0]         FILL_FULL = 3'd4;
    localparam logic signed [21:0] HR_MAX    = 22'sd32767;
    localparam logic signed [21:0] HR_MIN    = -22'sd32768;

    logic                    dec_rate_q;
    logic                    rate_chg;

    logic [21:0]             hz1, hz2, hz3;
    logic [21:0]             hd1, hd2, hd3;
    logic [18:0]             hr_raw;
    logic [2:0]              hr_fill;
    logic                    hr_ready;
    logic signed [21:0]      hr_ext;
    logic signed [21:0]      hr_scaled;
    logic [15:0]             hr_clamped;
    logic                    hr_clip;
    logic                    hr_take;

    logic [21:0]             lz1, lz2, lz3;
    logic [21:0]             ld1, ld2, ld3;
    logic [12:0]             lr_raw;
    logic [2:0]              lr_fill;
    logic [2:0]              lr_fill_nx;
    logic                    lr_upd;
    logic                    lr_take;
    logic signed [14:0]      lr_diff;
    logic [14:0]             lr_abs;
    logic [17:0]             lr_wide;
    logic [11:0]             lr_mag_nx;

    logic [OC_PERSIST_W-1:0] oc_cnt;
    logic [OC_PERSIST_W-1:0] oc_cnt_nx;
    logic [OC_PERSIST_W-1:0] persist_eff;
    logic                    lr_over;
    logic                    trip_set;

    logic                    unused_bits;

    // A rate change invalidates everything in flight; the fill counters flush stale comb state.
    assign rate_chg = dec_rate != dec_rate_q;

    assign hd1 = cn_in - hz1;
    assign hd2 = hd1 - hz2;
    assign hd3 = hd2 - hz3;
    assign ld1 = cn_in - lz1;
    assign ld2 = ld1 - lz2;
    assign ld3 = ld2 - lz3;

    assign hr_ready    = hr_fill == FILL_FULL;
    assign hr_take     = latch_en && hr_ready && !rate_chg;
    assign lr_take     = lr_upd && !rate_chg;
    assign unused_bits = ^{hd3[21:19], ld3[21:13]};

    always_ff @(posedge clk_adc or negedge reset_adc_n) begin
        if (!reset_adc_n) begin
            dec_rate_q <= 1'b0;
            hz1        <= '0;
            hz2        <= '0;
            hz3        <= '0;
            hr_raw     <= '0;
            hr_fill    <= '0;
        end else begin
            dec_rate_q <= dec_rate;
            if (cnr64) begin
                hz1    <= cn_in;
                hz2    <= hd1;
                hz3    <= hd2;
                hr_raw <= hd3[18:0];
            end
            if (rate_chg)
                hr_fill <= '0;
            else if (cnr64 && !hr_ready)
                hr_fill <= hr_fill + 3'd1;
        end
    end

    // Re-centre the unipolar CIC output on zero and normalise both rates to full 16-bit scale.
    always_comb begin
        hr_ext     = signed'({3'b000, hr_raw});
        hr_clamped = '0;
        hr_clip    = 1'b0;
        if (dec_rate)
            hr_scaled = (hr_ext - 22'sd16384) <<< 1;
        else
            hr_scaled = (hr_ext - 22'sd131072) >>> 2;
        if (hr_scaled > HR_MAX) begin
            hr_clamped = 16'h7FFF;
            hr_clip    = 1'b1;
        end else if (hr_scaled < HR_MIN) begin
            hr_clamped = 16'h8000;
            hr_clip    = 1'b1;
        end else begin
            hr_clamped = hr_scaled[15:0];
        end
    end

    always_ff @(posedge clk_adc or negedge reset_adc_n) begin
        if (!reset_adc_n) begin
            result       <= '0;
            result_sat   <= 1'b0;
            result_valid <= 1'b0;
        end else begin
            result_valid <= hr_take;
            if (hr_take) begin
                result     <= hr_clamped;
                result_sat <= hr_clip;
            end
        end
    end

    always_comb begin
        lr_fill_nx = lr_fill;
        if (rate_chg)
            lr_fill_nx = '0;
        else if (cnr16 && lr_fill != FILL_FULL)
            lr_fill_nx = lr_fill + 3'd1;
    end

    always_ff @(posedge clk_adc or negedge reset_adc_n) begin
        if (!reset_adc_n) begin
            lz1     <= '0;
            lz2     <= '0;
            lz3     <= '0;
            lr_raw  <= '0;
            lr_fill <= '0;
            lr_upd  <= 1'b0;
        end else begin
            if (cnr16) begin
                lz1    <= cn_in;
                lz2    <= ld1;
                lz3    <= ld2;
                lr_raw <= ld3[12:0];
            end
            lr_fill <= lr_fill_nx;
            lr_upd  <= cnr16 && (lr_fill_nx == FILL_FULL);
        end
    end

    // Magnitude about mid-scale; the short-window rate is scaled up so both rates share one threshold.
    always_comb begin
        if (dec_rate)
            lr_diff = signed'({2'b00, lr_raw}) - 15'sd256;
        else
            lr_diff = signed'({2'b00, lr_raw}) - 15'sd2048;
        lr_abs    = lr_diff[14] ? $unsigned(-lr_diff) : $unsigned(lr_diff);
        lr_wide   = dec_rate ? {lr_abs, 3'b000} : {3'b000, lr_abs};
        lr_mag_nx = (lr_wide > 18'd4095) ? 12'hFFF : lr_wide[11:0];
    end

    assign lr_over     = lr_mag_nx > oc_threshold;
    assign persist_eff = (oc_persist == '0) ? OC_PERSIST_W'(1) : oc_persist;

    always_comb begin
        oc_cnt_nx = oc_cnt;
        if (rate_chg)
            oc_cnt_nx = '0;
        else if (lr_take) begin
            if (!lr_over)
                oc_cnt_nx = '0;
            else if (oc_cnt != '1)
                oc_cnt_nx = oc_cnt + OC_PERSIST_W'(1);
        end
    end

    assign trip_set = lr_take && lr_over && (oc_cnt_nx >= persist_eff);

    // A trip on the same edge as a clear must not be lost, so the set path has priority.
    always_ff @(posedge clk_adc or negedge reset_adc_n) begin
        if (!reset_adc_n) begin
            lr_mag  <= '0;
            oc_cnt  <= '0;
            oc_trip <= 1'b0;
        end else begin
            if (lr_take)
                lr_mag <= lr_mag_nx;
            oc_cnt <= oc_cnt_nx;
            if (trip_set)
                oc_trip <= 1'b1;
            else if (oc_clear)
                oc_trip <= 1'b0;
        end
    end

endmodule

// File: tb/tb_ssg_emb_sd_adc_comb.sv
// Bench for ssg_emb_sd_adc_comb: a bitstream-driven Sinc3 integrator model feeds the comb, and
// latched results are scoreboarded against constant expectations.
module tb_ssg_emb_sd_adc_comb;

    logic        clk_adc = 1'b0;
    logic        reset_adc_n;
    logic [21:0] cn_in;
    logic        cnr64;
    logic        cnr16;
    logic        latch_en;
    logic        dec_rate;
    logic [11:0] oc_threshold;
    logic [3:0]  oc_persist;
    logic        oc_clear;
    logic [15:0] result;
    logic        result_valid;
    logic        result_sat;
    logic [11:0] lr_mag;
    logic        oc_trip;

    typedef struct {
        logic        dr;
        logic [3:0]  pat;
        logic        wrap;
        logic [15:0] exp_res;
        logic        exp_sat;
        logic [11:0] exp_mag;
        string       name;
    } vec_t;

    typedef struct {
        int          cyc;
        logic [15:0] res;
        logic        sat;
        string       tag;
    } exp_t;

    vec_t        vecs[10];
    exp_t        sbq[$];
    int          tests = 0;
    int          fails = 0;
    int          cyc = 0;
    int          sc = 0;
    int          valid_seen = 0;
    int          v0;
    logic [21:0] delta1, cn1, cn2;
    logic [3:0]  pat;

    ssg_emb_sd_adc_comb #(.OC_PERSIST_W(4)) dut (
        .clk_adc      (clk_adc),
        .reset_adc_n  (reset_adc_n),
        .cn_in        (cn_in),
        .cnr64        (cnr64),
        .cnr16        (cnr16),
        .latch_en     (latch_en),
        .dec_rate     (dec_rate),
        .oc_threshold (oc_threshold),
        .oc_persist   (oc_persist),
        .oc_clear     (oc_clear),
        .result       (result),
        .result_valid (result_valid),
        .result_sat   (result_sat),
        .lr_mag       (lr_mag),
        .oc_trip      (oc_trip)
    );

    always #5 clk_adc = ~clk_adc;

    task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // One bit of modulator output per clock through three integrators; strobes every M samples.
    task automatic apply_stimulus(input logic latch);
        logic b;
        int   m_hr;
        int   m_lr;
        m_hr     = dec_rate ? 32 : 64;
        m_lr     = dec_rate ? 8 : 16;
        b        = pat[3 - (sc % 4)];
        delta1   = delta1 + 22'(b);
        cn1      = cn1 + delta1;
        cn2      = cn2 + cn1;
        cn_in    = cn2;
        cnr64    = (sc % m_hr) == (m_hr - 1);
        cnr16    = (sc % m_lr) == (m_lr - 1);
        latch_en = latch;
        @(posedge clk_adc);
        #1;
        cyc++;
        sc++;
        cnr64    = 1'b0;
        cnr16    = 1'b0;
        latch_en = 1'b0;
        oc_clear = 1'b0;
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) apply_stimulus(1'b0);
    endtask

    task automatic expect_latch(input logic [15:0] res, input logic sat, input string tag);
        sbq.push_back('{cyc + 1, res, sat, tag});
        apply_stimulus(1'b1);
    endtask

    task automatic do_reset();
        reset_adc_n = 1'b0;
        cnr64 = 1'b0; cnr16 = 1'b0; latch_en = 1'b0; oc_clear = 1'b0;
        delta1 = '0; cn1 = '0; cn2 = '0; cn_in = '0; sc = 0;
        @(posedge clk_adc); #1; cyc++;
        @(posedge clk_adc); #1; cyc++;
        reset_adc_n = 1'b1;
    endtask

    always @(negedge clk_adc) begin : monitor
        exp_t e;
        if (reset_adc_n && result_valid) begin
            valid_seen++;
            if (sbq.size() == 0) begin
                tests++;
                fails++;
                $display("[TB] FAIL unexpected_valid: got result_valid=1 at cycle %0d, expected 0", cyc);
            end else begin
                e = sbq.pop_front();
                check_output({e.tag, "_latency"}, cyc, e.cyc);
                check_output({e.tag, "_result"}, result, e.res);
                check_output({e.tag, "_sat"}, result_sat, e.sat);
            end
        end
    end

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        vecs[0] = '{1'b0, 4'b1111, 1'b0, 16'h7FFF, 1'b1, 12'd2048, "ones_m64"};
        vecs[1] = '{1'b0, 4'b1010, 1'b0, 16'h0000, 1'b0, 12'd0,    "half_m64"};
        vecs[2] = '{1'b1, 4'b0000, 1'b0, 16'h8000, 1'b0, 12'd2048, "zeros_m32"};
        vecs[3] = '{1'b0, 4'b1110, 1'b0, 16'h4000, 1'b0, 12'd1024, "q3_m64"};
        vecs[4] = '{1'b1, 4'b1110, 1'b0, 16'h4000, 1'b0, 12'd1024, "q3_m32"};
        vecs[5] = '{1'b1, 4'b1111, 1'b0, 16'h7FFF, 1'b1, 12'd2048, "ones_m32"};
        vecs[6] = '{1'b0, 4'b0000, 1'b0, 16'h8000, 1'b0, 12'd2048, "zeros_m64"};
        vecs[7] = '{1'b0, 4'b1000, 1'b0, 16'hC000, 1'b0, 12'd1024, "q1_m64"};
        vecs[8] = '{1'b0, 4'b1010, 1'b1, 16'h0000, 1'b0, 12'd0,    "wrap_m64"};
        vecs[9] = '{1'b1, 4'b1010, 1'b0, 16'h0000, 1'b0, 12'd0,    "half_m32"};

        dec_rate = 1'b0; oc_threshold = 12'hFFF; oc_persist = 4'd0; pat = 4'b0000;
        do_reset();
        @(negedge clk_adc);
        check_output("rst_result", result, 16'h0);
        check_output("rst_valid", result_valid, 1'b0);
        check_output("rst_sat", result_sat, 1'b0);
        check_output("rst_lr_mag", lr_mag, 12'h0);
        check_output("rst_oc_trip", oc_trip, 1'b0);

        for (int i = 0; i < 10; i++) begin
            dec_rate = vecs[i].dr;
            do_reset();
            if (vecs[i].wrap) cn2 = 22'h3FFFFF - 22'd3000;
            pat = vecs[i].pat;
            run(vecs[i].dr ? 5 * 32 : 5 * 64);
            expect_latch(vecs[i].exp_res, vecs[i].exp_sat, vecs[i].name);
            run(3);
            @(negedge clk_adc);
            check_output({vecs[i].name, "_pending"}, sbq.size(), 0);
            check_output({vecs[i].name, "_lr_mag"}, lr_mag, vecs[i].exp_mag);
            sbq.delete();
        end

        // Mid-operation async reset, then a latch after only three strobes
        dec_rate = 1'b0;
        do_reset();
        pat = 4'b1111;
        run(320);
        expect_latch(16'h7FFF, 1'b1, "pre_reset");
        run(3);
        reset_adc_n = 1'b0;
        #2;
        check_output("async_rst_result", result, 16'h0);
        check_output("async_rst_sat", result_sat, 1'b0);
        check_output("async_rst_lr_mag", lr_mag, 12'h0);
        do_reset();
        v0 = valid_seen;
        run(3 * 64);
        apply_stimulus(1'b1);
        run(3);
        @(negedge clk_adc);
        check_output("fill3_no_valid", valid_seen - v0, 0);
        check_output("fill3_result", result, 16'h0);

        // Rate toggle: early latch is ignored and old result held
        dec_rate = 1'b0;
        do_reset();
        pat = 4'b1110;
        run(320);
        expect_latch(16'h4000, 1'b0, "pre_toggle");
        run(3);
        dec_rate = 1'b1;
        run(64);
        v0 = valid_seen;
        apply_stimulus(1'b1);
        run(3);
        @(negedge clk_adc);
        check_output("toggle_no_valid", valid_seen - v0, 0);
        check_output("toggle_result_held", result, 16'h4000);
        check_output("toggle_sat_held", result_sat, 1'b0);
        run(5 * 32);
        expect_latch(16'h4000, 1'b0, "post_toggle");
        run(3);
        @(negedge clk_adc);
        check_output("post_toggle_pending", sbq.size(), 0);
        sbq.delete();

        // Overcurrent persistence, clear-vs-trip priority, and clear once input is back to mid-scale
        dec_rate = 1'b0;
        oc_threshold = 12'd1000;
        oc_persist = 4'd3;
        do_reset();
        pat = 4'b1111;
        run(65);
        @(negedge clk_adc);
        check_output("oc_upd1_mag", lr_mag, 12'd2048);
        check_output("oc_upd1_trip", oc_trip, 1'b0);
        run(16);
        @(negedge clk_adc);
        check_output("oc_upd2_trip", oc_trip, 1'b0);
        run(16);
        @(negedge clk_adc);
        check_output("oc_upd3_trip", oc_trip, 1'b1);
        check_output("oc_upd3_mag", lr_mag, 12'd2048);
        run(15);
        oc_clear = 1'b1;
        apply_stimulus(1'b0);
        @(negedge clk_adc);
        check_output("oc_clear_vs_trip", oc_trip, 1'b1);
        pat = 4'b1010;
        run(128);
        @(negedge clk_adc);
        check_output("oc_half_mag", lr_mag, 12'd0);
        check_output("oc_sticky", oc_trip, 1'b1);
        oc_clear = 1'b1;
        apply_stimulus(1'b0);
        @(negedge clk_adc);
        check_output("oc_cleared", oc_trip, 1'b0);
        run(32);
        @(negedge clk_adc);
        check_output("oc_stays_clear", oc_trip, 1'b0);

        // Zero persistence behaves as one: trip on the first over-threshold update
        oc_persist = 4'd0;
        do_reset();
        pat = 4'b1111;
        run(65);
        @(negedge clk_adc);
        check_output("oc_persist0_trip", oc_trip, 1'b1);

        check_output("final_pending", sbq.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
